sop_sweep: RTL and testbench

Sequential truth-table characterizer for 3-input combinational cells such as the switch-level sum-of-products gates. On a start request it drives all eight input vectors {a,b,c} = 000…111 into the cell under test, waits a programmable settle time per vector, and samples the cell output. It assembles the 8-bit minterm vector, compares it with an expected vector, and reports pass/fail with a done pulse. It sits between a test controller and the cell: it drives the cell's inputs and reads its output.

---
 rtl/sop_pkg.sv | 21 ++
 rtl/sop_settle_timer.sv | 32 +++
 rtl/sop_sweep.sv | 102 ++++++++++
 tb/tb_sop_sweep.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared types and constants for the 3-input truth-table sweeper.
// Holds the FSM state encoding and the settle-counter width helper.
package sop_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;

  // Counter width for a settle count of 0..settle; never narrower than one bit.
  function automatic int cnt_width(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sop_settle_timer.sv
// Per-vector settle counter: counts 0..SETTLE while enabled and flags the
// sampling cycle with expire. clear has priority over enable.
module sop_settle_timer
  import sop_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == LAST);

endmodule

// File: rtl/sop_sweep.sv
// Drives all eight {a,b,c} vectors into a 3-input cell, samples y after a
// settle delay, and compares the captured minterm vector against expected.
module sop_sweep
  import sop_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] minterms,
  output logic [7:0] mismatch,
  output logic       pass
);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [7:0]       exp_latch;
  logic [7:0]       captured;
  logic             accept;
  logic             capture;
  logic             expire;
  logic             last_vec;

  assign accept   = (state == IDLE) && start;
  assign capture  = (state == DRIVE) && expire;
  assign last_vec = (idx == IDX_W'(NUM_VEC - 1));

  sop_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (accept || capture),
    .enable(state == DRIVE),
    .expire(expire)
  );

  // Minterm vector including the sample taken on this edge.
  always_comb begin
    captured      = minterms;
    captured[idx] = y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRIVE;
      DRIVE:   if (capture && last_vec) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    {a, b, c} = (state == DRIVE) ? idx : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      minterms  <= '0;
      mismatch  <= '0;
      pass      <= 1'b0;
      exp_latch <= '0;
    end else if (accept) begin
      idx       <= '0;
      minterms  <= '0;
      mismatch  <= '0;
      pass      <= 1'b0;
      exp_latch <= expected;
    end else if (capture) begin
      minterms <= captured;
      if (last_vec) begin
        // Result registers become valid together with the done cycle.
        mismatch <= captured ^ exp_latch;
        pass     <= (captured == exp_latch);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sop_sweep.sv
// Directed bench for sop_sweep: a SETTLE=2 instance driving a selectable
// cell model and a SETTLE=0 instance driving a constant-1 cell.
module tb_sop_sweep;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [7:0] expected, expected1;
  logic       y, y1;
  logic       a, b, c, busy, done, pass;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] minterms, mismatch, minterms1, mismatch1;
  int         mode;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // Cell models: 0 = (a&b)|c, 1 = a^b^c, 2 = a.
  assign y  = (mode == 0) ? ((a & b) | c) : (mode == 1) ? (a ^ b ^ c) : a;
  assign y1 = 1'b1;

  sop_sweep #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .y(y),
    .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .minterms(minterms), .mismatch(mismatch), .pass(pass)
  );

  sop_sweep #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
    .minterms(minterms1), .mismatch(mismatch1), .pass(pass1)
  );

  typedef struct {
    int         md;
    logic [7:0] ex;
    logic [7:0] mt;
    logic [7:0] mm;
    logic       ps;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_abc"}, 8'({a, b, c}), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_done"}, 8'(done), 8'd0);
    chk({tag, "_minterms"}, minterms, 8'h00);
    chk({tag, "_mismatch"}, mismatch, 8'h00);
    chk({tag, "_pass"}, 8'(pass), 8'd0);
  endtask

  // One full sweep on the SETTLE=2 instance. All actions at negedge.
  // poke: extra start pulses at t=5, t=23 and in the done cycle.
  // chg: expected input changed to 0x00 at t=10.
  task automatic run_sweep(input int md, input logic [7:0] ex, input bit poke, input bit chg,
                           input logic [7:0] r_mt, input logic [7:0] r_mm, input logic r_ps);
    int t;
    bit abc_ok;
    mode     = md;
    expected = ex;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    t      = 0;
    abc_ok = 1'b1;
    chk("busy_after_start", 8'(busy), 8'd1);
    chk("cleared_on_start", {minterms[6:0], pass}, 8'h00);
    while (!done && t < 100) begin
      if (t >= 24 || {a, b, c} !== 3'(t / 3)) abc_ok = 1'b0;
      start = poke && (t == 5 || t == 23);
      if (chg && t == 10) expected = 8'h00;
      @(negedge clk);
      t++;
    end
    chk("latency", 8'(t), 8'd24);
    chk("abc_sequence", 8'(abc_ok), 8'd1);
    chk("minterms", minterms, r_mt);
    chk("mismatch", mismatch, r_mm);
    chk("pass", 8'(pass), 8'(r_ps));
    chk("abc_in_done", 8'({a, b, c}), 8'd0);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", 8'(done), 8'd0);
    chk("idle_after_done", 8'(busy), 8'd0);
    chk("result_hold", minterms, r_mt);
    $display("sweep mode=%0d expect=0x%02h latency=%0d minterms=0x%02h mismatch=0x%02h pass=%0b",
             md, ex, t, minterms, mismatch, pass);
  endtask

  initial begin
    int t;
    int n_done;
    bit abc_ok;

    vecs[0] = '{md: 0, ex: 8'hEA, mt: 8'hEA, mm: 8'h00, ps: 1'b1};
    vecs[1] = '{md: 0, ex: 8'hE8, mt: 8'hEA, mm: 8'h02, ps: 1'b0};
    vecs[2] = '{md: 1, ex: 8'h96, mt: 8'h96, mm: 8'h00, ps: 1'b1};
    vecs[3] = '{md: 1, ex: 8'h69, mt: 8'h96, mm: 8'hFF, ps: 1'b0};
    vecs[4] = '{md: 2, ex: 8'hF1, mt: 8'hF0, mm: 8'h01, ps: 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    start1    = 1'b0;
    expected  = 8'h00;
    expected1 = 8'h00;
    mode      = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_dut0", {busy1, done1, pass1, a1, b1, c1, 2'b00}, 8'h00);
    chk("reset_dut0_regs", minterms1 | mismatch1, 8'h00);

    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i].md, vecs[i].ex, 1'b0, 1'b0, vecs[i].mt, vecs[i].mm, vecs[i].ps);
    end

    // Ignored start pulses, then a back-to-back start right after done.
    run_sweep(0, 8'hEA, 1'b1, 1'b0, 8'hEA, 8'h00, 1'b1);
    run_sweep(0, 8'hE8, 1'b0, 1'b0, 8'hEA, 8'h02, 1'b0);

    // expected changes mid-sweep; the latched value must be used.
    run_sweep(0, 8'hEA, 1'b0, 1'b1, 8'hEA, 8'h00, 1'b1);

    // Asynchronous reset while vector 4 is driven.
    mode     = 0;
    expected = 8'hEA;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("abc_before_rst", 8'({a, b, c}), 8'd4);
    chk("partial_minterms", minterms, 8'h0A);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("no_done_after_rst", 8'(n_done), 8'd0);
    $display("reset abort: done pulses after abort=%0d", n_done);
    run_sweep(0, 8'hEA, 1'b0, 1'b0, 8'hEA, 8'h00, 1'b1);

    // SETTLE=0 instance with a constant-1 cell.
    expected1 = 8'hFF;
    start1    = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    t      = 0;
    abc_ok = 1'b1;
    while (!done1 && t < 100) begin
      if (t >= 8 || {a1, b1, c1} !== 3'(t)) abc_ok = 1'b0;
      @(negedge clk);
      t++;
    end
    chk("s0_latency", 8'(t), 8'd8);
    chk("s0_abc_sequence", 8'(abc_ok), 8'd1);
    chk("s0_minterms", minterms1, 8'hFF);
    chk("s0_mismatch", mismatch1, 8'h00);
    chk("s0_pass", 8'(pass1), 8'd1);
    $display("sweep settle=0 expect=0xff latency=%0d minterms=0x%02h pass=%0b", t, minterms1, pass1);
    @(negedge clk);
    chk("s0_done_one_cycle", 8'(done1), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
